// File: rtl/div_seq_unit.sv
// Multicycle 32-bit restoring divider answering the DivInit/DivStop/DivZero handshake.
// Optional DIV_UNSIGNED_EN adds a div_unsigned input selecting DIVU semantics.
module div_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             div_init,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic             div_stop,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FIX,
    DONE,
    ZERO
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             sign_q;
  logic             sign_r;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = ~div_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  // Operand magnitudes captured at start; unsigned ops pass straight through.
  always_comb begin
    a_neg = signed_op & a_in[WIDTH-1];
    b_neg = signed_op & b_in[WIDTH-1];
    a_mag = a_neg ? WIDTH'(-a_in) : a_in;
    b_mag = b_neg ? WIDTH'(-b_in) : b_in;
  end

  // One restoring step; a borrow out of the WIDTH+1 subtract means rem < divisor.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs};
    q_bit     = ~rem_diff[WIDTH];
    rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_stop <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
    end else begin
      div_stop <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (div_init) begin
            dvd    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            busy   <= 1'b1;
            if (b_in == '0) begin
              state    <= ZERO;
              div_stop <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state   <= RUN;
              counter <= CNT_W'(WIDTH);
            end
          end
        end
        RUN: begin
          rem     <= rem_step;
          dvd     <= {dvd[WIDTH-2:0], q_bit};
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Truncating division: remainder follows the dividend's sign.
          lo_out   <= sign_q ? WIDTH'(-dvd) : dvd;
          hi_out   <= sign_r ? WIDTH'(-rem) : rem;
          div_stop <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ZERO: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: directed vectors with hand-computed results.
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        div_init;
  logic        div_unsigned;
  logic        div_stop;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;

  div_seq_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_in         (a_in),
    .b_in         (b_in),
    .div_init     (div_init),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned (div_unsigned),
`endif
    .div_stop     (div_stop),
    .div_zero     (div_zero),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every div_stop must match the oldest expected result, at the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (div_zero && !div_stop) begin
        n_checks++;
        n_fail++;
        $display("FAIL zero_without_stop: div_zero=1 div_stop=0 at cycle %0d", cyc);
      end
      if (div_stop) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_stop: div_stop=1 with nothing pending at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("stop_cycle", 32'(cyc), 32'(e.at));
          chk("div_zero", {31'b0, div_zero}, {31'b0, e.zero});
          chk("hi_out", hi_out, e.hi);
          chk("lo_out", lo_out, e.lo);
        end
      end
    end
  end

  // Issues a one-cycle start pulse; returns #1 after the capturing edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] hi,
                       input logic [31:0] lo, input logic z, input bit push);
    @(posedge clk); #1;
    a_in     = a;
    b_in     = b;
    div_init = 1'b1;
    if (push) sb.push_back('{at: cyc + (z ? 1 : 34), zero: z, hi: hi, lo: lo});
    @(posedge clk); #1;
    div_init = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset        = 1'b1;
    a_in         = '0;
    b_in         = '0;
    div_init     = 1'b0;
    div_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stop", {31'b0, div_stop}, 32'd0);
    chk("reset_zero", {31'b0, div_zero}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    reset = 1'b0;

    // 7 / 2 with busy profile: high through DONE, low once back in IDLE
    start(32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b1);
    for (int i = 1; i <= 34; i++) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("busy_after", {31'b0, busy}, 32'd0);
    wait_done();

    // Divide by zero: immediate flagged stop, results untouched
    start(32'd5, 32'd0, 32'd1, 32'd3, 1'b1, 1'b1);
    chk("busy_zero", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_idle_after_zero", {31'b0, busy}, 32'd0);
    wait_done();

    start(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done();
    start(32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1);
    wait_done();
    start(32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done();
    start(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
    wait_done();
    start(32'h7FFF_FFFF, 32'd1, 32'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    wait_done();
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b1);
    wait_done();
    start(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_done();

    // Reset during cycle 10 abandons the op without a stop
    start(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_stop", {31'b0, div_stop}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    repeat (40) @(posedge clk);
    start(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    wait_done();

    // Starts while busy (RUN at cycle 5, FIX at cycle 33) are ignored
    start(32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    a_in = 32'd100; b_in = 32'd7; div_init = 1'b1;
    @(posedge clk); #1;
    div_init = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    a_in = 32'd50; b_in = 32'd0; div_init = 1'b1;
    @(posedge clk); #1;
    div_init = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);

`ifdef DIV_UNSIGNED_EN
    div_unsigned = 1'b1;
    start(32'hFFFF_FFFE, 32'd2, 32'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    wait_done();
    div_unsigned = 1'b0;
    start(32'hFFFF_FFFE, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
